aes_subbytes_engine: RTL and testbench

Parametrised AES SubBytes / InvSubBytes engine that replaces the fixed one-byte-at-a-time substitution wrapper in the cipher datapath. It takes a 128-bit state and runs it through LANES parallel S-box lanes over 16/LANES beats. It supports forward and inverse substitution and an optional registered S-box stage. It connects to the round controller through a start/busy/done handshake and holds its result until the next accepted start.

---
 rtl/aes_subbytes_engine.sv | 213 +++++++++++++++++++++
 tb/tb_aes_subbytes_engine.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_subbytes_engine.sv
// aes_subbytes_engine
// Runs a 128-bit AES state through LANES parallel S-box lanes, one group
// of LANES bytes per beat, for forward (SubBytes) or inverse (InvSubBytes)
// substitution. The S-box is computed from GF(2^8) arithmetic instead of a
// 256-entry table, so each lane is a pure function of its input byte.
// Results are written back into the work register in place. dout is only
// updated with the complete state when the engine enters DONE.

module aes_subbytes_engine #(
    parameter int LANES    = 1,
    parameter int SBOX_LAT = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         inverse,
    input  logic [127:0] din,
    output logic         busy,
    output logic         done,
    output logic [127:0] dout
);

    localparam int N  = 16 / LANES;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int LW = 8 * LANES;
    localparam logic [CW-1:0] LAST_BEAT = CW'(N - 1);

    // Reject lane counts that do not split the 16-byte state evenly
    // and latencies the lane pipeline does not implement.
    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
        $error("aes_subbytes_engine: LANES must be 1, 2, 4, 8 or 16");
    end
    if (!(SBOX_LAT == 0 || SBOX_LAT == 1)) begin : g_bad_lat
        $error("aes_subbytes_engine: SBOX_LAT must be 0 or 1");
    end

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [127:0]  work_q;
    logic [127:0]  work_next;
    logic          mode_q;
    logic [CW-1:0] beat_cnt;
    logic          accept;

    logic [6:0]    issue_base;
    logic [LW-1:0] lane_in;
    logic [LW-1:0] lane_out;

    logic          wr_en;
    logic [6:0]    wr_base;
    logic [LW-1:0] wr_data;

    // Multiply by x in GF(2^8) with the AES reduction polynomial.
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // Shift-and-add multiplication in GF(2^8).
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] t;
        p = 8'h00;
        t = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                p = p ^ t;
            end
            t = xtime(t);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 (square-and-multiply); maps 0 to 0.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] s;
        logic [7:0] r;
        s = x;
        r = 8'h01;
        for (int i = 1; i < 8; i++) begin
            s = gf_mul(s, s);
            r = gf_mul(r, s);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int unsigned n);
        return (b << n) | (b >> (8 - n));
    endfunction

    // Forward: inverse then affine map. Inverse: inverse affine map then inverse.
    function automatic logic [7:0] sbox_byte(input logic [7:0] b, input logic inv);
        logic [7:0] t;
        if (inv) begin
            t = rotl8(b, 1) ^ rotl8(b, 3) ^ rotl8(b, 6) ^ 8'h05;
            return gf_inv(t);
        end
        t = gf_inv(b);
        return t ^ rotl8(t, 1) ^ rotl8(t, 2) ^ rotl8(t, 3) ^ rotl8(t, 4) ^ 8'h63;
    endfunction

    assign accept = start && ((state == ST_IDLE) || (state == ST_DONE));

    // State register; reset wins over any pending start.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: one beat per RUN cycle, optional DRAIN for the lane pipeline.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (start) state_next = ST_RUN;
            ST_RUN:   if (beat_cnt == LAST_BEAT) state_next = (SBOX_LAT == 1) ? ST_DRAIN : ST_DONE;
            ST_DRAIN: state_next = ST_DONE;
            ST_DONE:  state_next = start ? ST_RUN : ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Handshake outputs decoded directly from the state.
    always_comb begin
        busy = (state == ST_RUN) || (state == ST_DRAIN);
        done = (state == ST_DONE);
    end

    // Select the byte group for the current beat and run it through the lanes.
    always_comb begin
        issue_base = 7'(beat_cnt) * 7'(LW);
        lane_in    = work_q[issue_base +: LW];
        lane_out   = '0;
        for (int j = 0; j < LANES; j++) begin
            lane_out[8*j +: 8] = sbox_byte(lane_in[8*j +: 8], mode_q);
        end
    end

    if (SBOX_LAT == 1) begin : g_piped
        logic          pipe_valid;
        logic [6:0]    pipe_base;
        logic [LW-1:0] pipe_data;

        // Lane results and their byte position travel together one cycle later.
        always_ff @(posedge clk) begin
            if (rst) begin
                pipe_valid <= 1'b0;
                pipe_base  <= '0;
                pipe_data  <= '0;
            end else begin
                pipe_valid <= (state == ST_RUN);
                pipe_base  <= issue_base;
                pipe_data  <= lane_out;
            end
        end

        // Write-back comes from the pipeline register.
        always_comb begin
            wr_en   = pipe_valid;
            wr_base = pipe_base;
            wr_data = pipe_data;
        end
    end else begin : g_comb
        // Write-back comes straight from the lanes in the issuing cycle.
        always_comb begin
            wr_en   = (state == ST_RUN);
            wr_base = issue_base;
            wr_data = lane_out;
        end
    end

    // Work register with this cycle's write-back merged in; also feeds dout.
    always_comb begin
        work_next = work_q;
        if (wr_en) begin
            work_next[wr_base +: LW] = wr_data;
        end
    end

    // Datapath: capture on accept, in-place write-back, publish on entry to DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            work_q   <= '0;
            mode_q   <= 1'b0;
            beat_cnt <= '0;
            dout     <= '0;
        end else begin
            if (accept) begin
                work_q   <= din;
                mode_q   <= inverse;
                beat_cnt <= '0;
            end else begin
                work_q <= work_next;
                if ((state == ST_RUN) && (beat_cnt != LAST_BEAT)) begin
                    beat_cnt <= beat_cnt + 1'b1;
                end
            end
            if (state_next == ST_DONE) begin
                dout <= work_next;
            end
        end
    end

endmodule

// File: tb/tb_aes_subbytes_engine.sv
// tb_aes_subbytes_engine
// Scoreboard bench: stimulus pushes expected results into a queue, a monitor
// pops on every done pulse. Expected S-box values come from tables built by
// the generator-walk construction (powers of 3 and their inverses), not from
// the GF exponentiation the design uses. A bank of ten extra instances covers
// every LANES/SBOX_LAT combination for the inverse round trip.

module tb_aes_subbytes_engine;

    localparam int M_LANES   = 1;
    localparam int M_LAT     = 1;
    localparam int M_LATENCY = 16 / M_LANES + 1 + M_LAT;
    localparam int M_BUSY    = 16 / M_LANES + M_LAT;

    localparam logic [127:0] VEC_B     = 128'h0848f8e92a8dc69a2be2f4a0bee33d19;
    localparam logic [127:0] VEC_B_SUB = 128'h3052411ee55db4b8f198bfe0ae1127d4;
    localparam logic [127:0] ALL63     = {16{8'h63}};

    typedef struct {
        logic [127:0] data;
        int           t0;
    } exp_t;

    logic         clk;
    logic         rst;
    logic         start;
    logic         inverse;
    logic [127:0] din;
    logic         busy;
    logic         done;
    logic [127:0] dout;

    logic         sw_start;
    logic         sw_inv;
    logic [127:0] sw_din;

    int           cyc       = 0;
    logic         rst_seen  = 1'b0;
    logic         mon_en    = 1'b0;
    int           n_checks  = 0;
    int           n_pass    = 0;
    int           sweep_t0  = -1000;
    logic [127:0] sweep_exp = '0;

    exp_t         exp_q[$];
    logic [127:0] hold_exp  = '0;
    int           busy_cnt  = 0;
    logic         prev_done = 1'b0;

    logic [7:0]   fwd_tab[256];
    logic [7:0]   inv_tab[256];

    aes_subbytes_engine #(.LANES(M_LANES), .SBOX_LAT(M_LAT)) u_dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .inverse(inverse),
        .din(din),
        .busy(busy),
        .done(done),
        .dout(dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_seen <= rst;
    end

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    // Walk the multiplicative group with generator 3; q tracks 3^-k.
    task automatic buildTables();
        logic [7:0] p;
        logic [7:0] q;
        logic [7:0] x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b00};
            q = q ^ {q[3:0], 4'h0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
            fwd_tab[p] = x ^ 8'h63;
        end while (p != 8'h01);
        fwd_tab[0] = 8'h63;
        for (int i = 0; i < 256; i++) begin
            inv_tab[fwd_tab[i]] = 8'(i);
        end
    endtask

    function automatic logic [127:0] refSub(input logic [127:0] s, input logic inv);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) begin
            r[8*i +: 8] = inv ? inv_tab[s[8*i +: 8]] : fwd_tab[s[8*i +: 8]];
        end
        return r;
    endfunction

    function automatic logic [127:0] randState();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Drive a start for one cycle and record what the scoreboard should see.
    task automatic applyStimulus(input logic [127:0] d, input logic inv, input logic [127:0] expv);
        exp_t e;
        start   = 1'b1;
        din     = d;
        inverse = inv;
        e.data  = expv;
        e.t0    = cyc;
        exp_q.push_back(e);
        @(negedge clk);
        start   = 1'b0;
        din     = randState();
        inverse = ~inv;
    endtask

    task automatic waitDrain();
        for (int k = 0; k < 100 && exp_q.size() != 0; k++) begin
            @(negedge clk);
        end
        checkOutput("scoreboard_drained", 128'(exp_q.size()), 128'(0));
    endtask

    // Monitor: pop the scoreboard on every done pulse, otherwise dout must hold.
    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            if (rst_seen) begin
                hold_exp = '0;
                busy_cnt = 0;
            end
            if (busy) busy_cnt++;
            if (done) begin
                checkOutput("busy_with_done", 128'(busy), 128'(0));
                checkOutput("done_two_cycles", 128'(prev_done), 128'(0));
                checkOutput("done_expected", 128'(exp_q.size() != 0), 128'(1));
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    checkOutput("dout", dout, e.data);
                    checkOutput("latency", 128'(cyc - e.t0), 128'(M_LATENCY));
                    checkOutput("busy_cycles", 128'(busy_cnt), 128'(M_BUSY));
                    hold_exp = e.data;
                end
                busy_cnt = 0;
            end else begin
                checkOutput("dout_hold", dout, hold_exp);
            end
            prev_done = done;
        end
    end

    // One instance per LANES/SBOX_LAT pair; done must land exactly LAT cycles after start.
    for (genvar gi = 0; gi < 10; gi++) begin : g_sw
        localparam int L   = 1 << (gi % 5);
        localparam int S   = gi / 5;
        localparam int LAT = 16 / L + 1 + S;

        logic         sw_busy;
        logic         sw_done;
        logic [127:0] sw_dout;

        aes_subbytes_engine #(.LANES(L), .SBOX_LAT(S)) u_sw (
            .clk(clk),
            .rst(rst),
            .start(sw_start),
            .inverse(sw_inv),
            .din(sw_din),
            .busy(sw_busy),
            .done(sw_done),
            .dout(sw_dout)
        );

        always @(negedge clk) begin
            if (mon_en && (sw_done || (cyc == sweep_t0 + LAT))) begin
                checkOutput($sformatf("sweep_L%0d_S%0d_done_timing", L, S),
                            128'(sw_done), 128'(cyc == sweep_t0 + LAT));
                if (sw_done) begin
                    checkOutput($sformatf("sweep_L%0d_S%0d_dout", L, S), sw_dout, sweep_exp);
                    checkOutput($sformatf("sweep_L%0d_S%0d_busy", L, S), 128'(sw_busy), 128'(0));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got %0d checks, required completion", n_checks);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [127:0] d;
        logic         inv;
        int           gap;

        buildTables();
        rst      = 1'b1;
        start    = 1'b1;
        inverse  = 1'b0;
        din      = randState();
        sw_start = 1'b0;
        sw_inv   = 1'b0;
        sw_din   = '0;

        // Reset held with start asserted: nothing may start.
        @(posedge clk);
        repeat (3) begin
            @(negedge clk);
            checkOutput("reset_busy", 128'(busy), 128'(0));
            checkOutput("reset_done", 128'(done), 128'(0));
            checkOutput("reset_dout", dout, 128'(0));
            din = randState();
        end
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);
        checkOutput("post_reset_busy", 128'(busy), 128'(0));
        checkOutput("post_reset_done", 128'(done), 128'(0));
        mon_en = 1'b1;

        // FIPS-197 round 1 SubBytes vector.
        $display("[TB] FIPS-197 forward vector");
        applyStimulus(VEC_B, 1'b0, VEC_B_SUB);
        waitDrain();
        repeat (2) @(negedge clk);

        // Back-to-back: second start issued in the DONE cycle.
        $display("[TB] back-to-back");
        applyStimulus(128'(0), 1'b0, ALL63);
        repeat (M_LATENCY - 1) @(negedge clk);
        checkOutput("b2b_in_done", 128'(done), 128'(1));
        applyStimulus(ALL63, 1'b1, 128'(0));
        waitDrain();
        repeat (2) @(negedge clk);

        // Starts during RUN and DRAIN must be ignored.
        $display("[TB] ignored starts while busy");
        d   = randState();
        inv = 1'($urandom_range(0, 1));
        applyStimulus(d, inv, refSub(d, inv));
        for (int k = 0; k < M_LATENCY - 1; k++) begin
            start   = 1'b1;
            din     = randState();
            inverse = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        start = 1'b0;
        waitDrain();
        repeat (5) @(negedge clk);

        // Random operations with random idle gaps (gap 0 is back-to-back).
        $display("[TB] random operations");
        for (int i = 0; i < 8; i++) begin
            d   = randState();
            inv = 1'($urandom_range(0, 1));
            applyStimulus(d, inv, refSub(d, inv));
            repeat (M_LATENCY - 1) @(negedge clk);
            gap = $urandom_range(0, 2);
            repeat (gap) @(negedge clk);
        end
        waitDrain();
        repeat (2) @(negedge clk);

        // Reset at beat 5 abandons the operation.
        $display("[TB] reset mid-operation");
        d = randState();
        applyStimulus(d, 1'b0, refSub(d, 1'b0));
        repeat (5) @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        checkOutput("abort_busy", 128'(busy), 128'(0));
        checkOutput("abort_done", 128'(done), 128'(0));
        checkOutput("abort_dout", dout, 128'(0));
        rst = 1'b0;
        repeat (20) @(negedge clk);
        applyStimulus(128'(0), 1'b0, ALL63);
        waitDrain();
        repeat (2) @(negedge clk);

        // Every configuration: inverse of the FIPS result, then a random forward state.
        $display("[TB] configuration sweep");
        sweep_exp = VEC_B;
        sw_din    = VEC_B_SUB;
        sw_inv    = 1'b1;
        sweep_t0  = cyc;
        sw_start  = 1'b1;
        @(negedge clk);
        sw_start  = 1'b0;
        sw_din    = randState();
        repeat (20) @(negedge clk);

        d         = randState();
        sweep_exp = refSub(d, 1'b0);
        sw_din    = d;
        sw_inv    = 1'b0;
        sweep_t0  = cyc;
        sw_start  = 1'b1;
        @(negedge clk);
        sw_start  = 1'b0;
        sw_din    = randState();
        sw_inv    = 1'b1;
        repeat (20) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
